rf_mp: RTL and testbench
========================

# rf_mp

Parametrised multi-port register file, successor to the single-write/dual-read register file. It provides NR independently enabled read ports with one-cycle registered latency and write-to-read bypass, and NW write ports with a fixed priority rule. It adds an optional hard-wired zero entry and a sequential clear engine that zeroes the array without a reset. It sits in the datapath between the controller and the compute units as working storage.

## Interface
- BW, 8, data width in bits (signed data, stored as raw bits)
- DEPTH, 256, number of entries; AW = $clog2(DEPTH)
- NR, 2, number of read ports (≥1)
- NW, 2, number of write ports (≥1)
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- chip_en  in  1  global enable for port reads, port writes and clear start
- wr_en  in  NW  per-port write enable, active-high
- wr_addr  in  NW*AW  packed write addresses; port j at [j*AW +: AW]
- wr_data  in  NW*BW  packed write data; port j at [j*BW +: BW]
- rd_en  in  NR  per-port read enable
- rd_addr  in  NR*AW  packed read addresses
- rd_data  out  NR*BW  packed registered read data
- rd_valid  out  NR  per-port read-data valid, one-cycle pulse
- clr_req  in  1  request to zero all entries
- clr_busy  out  1  clear engine active

## Operation
- Reset (rst=1 at posedge): all entries 0, rd_data 0, rd_valid 0, clr_busy 0, FSM IDLE, clear counter 0. Reset overrides everything, including an in-flight clear, which aborts.
- Write: port j writes when chip_en & wr_en[j] & !clr_busy. If several ports target the same address in one cycle, the highest-indexed port wins. Writes with clr_busy=1 are dropped.
- Read: port i captures when chip_en & rd_en[i]. rd_data[i] is loaded with the entry contents, and rd_valid[i]=1 for the next cycle.
  - If not enabled, rd_valid[i]=0 and rd_data[i] holds its last value.
- Bypass (write-first): if a write that takes effect in the same cycle targets the read address, rd_data returns the written value, including the priority-winning port's data. A clear write also bypasses and returns 0.
- ZERO_REG=1: address 0 writes are ignored, and reads of address 0 return 0 regardless of bypass.
- Clear FSM, IDLE → CLEAR:
  - Transition on clr_req & chip_en in IDLE. clr_req in CLEAR is ignored.
  - In CLEAR, one entry per cycle is zeroed at address cnt, from 0 up to DEPTH-1. This runs independent of chip_en.
  - CLEAR → IDLE after entry DEPTH-1 is written; cnt returns to 0.
- Reads during CLEAR are served normally: already-cleared entries read 0, others read their old contents.
- Address width: out-of-range addresses (when DEPTH is not a power of two) are ignored for writes and read as 0.

## Timing
- Read latency: 1 cycle. rd_en/rd_addr sampled at edge T; rd_data/rd_valid valid after edge T and until edge T+1.
- Write latency: data written at edge T is visible to a read sampled at edge T (bypass) and all later reads.
- Clear, with clr_req sampled at edge T:
  - clr_busy goes high after edge T.
  - Entry k is zeroed at edge T+1+k.
  - clr_busy goes low after edge T+DEPTH, i.e. it is high for exactly DEPTH cycles.
- Back-to-back clr_req after clr_busy falls starts a new clear. No idle cycle is required.
- rst asserted at edge T takes effect after edge T. Port writes, reads and clear starts presented at edge T are discarded.

## Test plan
- Reset then read, BW=8, DEPTH=16, NR=2, NW=2: rst pulse, rd_en=2'b11, addr 3 and 15 → after 1 cycle rd_data={0,0}, rd_valid=2'b11; before any read, rd_valid=0 and rd_data=0.
- Write/read and conflict: port0 writes 0x5A and port1 writes 0xA5 to addr 4 in the same cycle, with read port 0 reading addr 4 in that cycle → rd_data[0]=0xA5 (bypass + priority). A later read of addr 4 also returns 0xA5.
- Gating: chip_en=0 with wr_en=2'b01 writing 0x77 to addr 2 → no write, rd_valid=0. Then chip_en=1 and read addr 2 → 0x00.
- ZERO_REG=1: write 0xFF to addr 0, read addr 0 in the same cycle and the next cycle → 0x00 both times.
- Clear: fill all 16 entries with 0x10+addr, pulse clr_req → clr_busy high for exactly 16 cycles.
  - A write of 0x33 to addr 9 during the clear is dropped.
  - A read of addr 12 at cycle 5 of the clear returns 0x1C.
  - A read of addr 2 at cycle 5 returns 0x00.
  - After clr_busy falls, every entry reads 0x00.
- Reset mid-clear: clr_req, then rst after 4 cycles → clr_busy=0 next cycle, all entries 0, and a new clr_req restarts from address 0.

Source files
------------

// File: rtl/rf_mp.sv
// Multi-port register file: NR registered read ports with write-first bypass,
// NW write ports (highest index wins), optional hard-wired zero entry, sequential clear.
module rf_mp #(
    parameter int BW       = 8,
    parameter int DEPTH    = 256,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int ZERO_REG = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chip_en,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic [NW*BW-1:0] wr_data,
    input  logic [NR-1:0]    rd_en,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*BW-1:0] rd_data,
    output logic [NR-1:0]    rd_valid,
    input  logic             clr_req,
    output logic             clr_busy
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_next;

    logic [BW-1:0] mem [DEPTH];

    logic [AW-1:0] wa [NW];
    logic [BW-1:0] wd [NW];
    logic [AW-1:0] ra [NR];
    logic [NW-1:0] wr_take;
    logic [BW-1:0] rd_next [NR];

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic is_zero_entry(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // ---------------- clear engine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (chip_en && clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                // Clearing proceeds regardless of chip_en once started.
                if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign clr_busy = (state == CLEAR);

    // ---------------- port decode ----------------
    always_comb begin
        for (int j = 0; j < NW; j++) begin
            wa[j]      = wr_addr[j*AW +: AW];
            wd[j]      = wr_data[j*BW +: BW];
            wr_take[j] = chip_en && wr_en[j] && !clr_busy
                         && in_range(wa[j]) && !is_zero_entry(wa[j]);
        end
        for (int i = 0; i < NR; i++) begin
            ra[i] = rd_addr[i*AW +: AW];
        end
    end

    // ---------------- storage ----------------
    // Ascending port order in the loop makes the highest-indexed port's NBA land last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (clr_busy) begin
            mem[cnt] <= '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wr_take[j]) begin
                    mem[wa[j]] <= wd[j];
                end
            end
        end
    end

    // ---------------- read path with write-first bypass ----------------
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rd_next[i] = '0;
            if (in_range(ra[i])) begin
                rd_next[i] = mem[ra[i]];
            end
            for (int j = 0; j < NW; j++) begin
                if (wr_take[j] && (wa[j] == ra[i])) begin
                    rd_next[i] = wd[j];
                end
            end
            if (clr_busy && (cnt == ra[i])) begin
                rd_next[i] = '0;
            end
            if (!in_range(ra[i]) || is_zero_entry(ra[i])) begin
                rd_next[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                rd_valid[i] <= chip_en && rd_en[i];
                if (chip_en && rd_en[i]) begin
                    rd_data[i*BW +: BW] <= rd_next[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: two instances (plain and zero-entry) share stimulus; a reference
// model feeds per-port expected queues that a monitor drains as read data appears.
module tb_rf_mp;

    localparam int BW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         chip_en;
    logic         clr_req;
    logic [1:0]   wr_en;
    logic [1:0]   rd_en;
    logic [AW-1:0] wa0, wa1, ra0, ra1;
    logic [BW-1:0] wd0, wd1;
    logic [2*AW-1:0] wr_addr_bus, rd_addr_bus;
    logic [2*BW-1:0] wr_data_bus;

    assign wr_addr_bus = {wa1, wa0};
    assign rd_addr_bus = {ra1, ra0};
    assign wr_data_bus = {wd1, wd0};

    logic [2*BW-1:0] rd_data_a, rd_data_b;
    logic [1:0]      rd_valid_a, rd_valid_b;
    logic            busy_a, busy_b;

    rf_mp #(.BW(BW), .DEPTH(DEPTH), .NR(2), .NW(2), .ZERO_REG(0)) u_plain (
        .clk(clk), .rst(rst), .chip_en(chip_en),
        .wr_en(wr_en), .wr_addr(wr_addr_bus), .wr_data(wr_data_bus),
        .rd_en(rd_en), .rd_addr(rd_addr_bus),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .clr_req(clr_req), .clr_busy(busy_a)
    );

    rf_mp #(.BW(BW), .DEPTH(DEPTH), .NR(2), .NW(2), .ZERO_REG(1)) u_zero (
        .clk(clk), .rst(rst), .chip_en(chip_en),
        .wr_en(wr_en), .wr_addr(wr_addr_bus), .wr_data(wr_data_bus),
        .rd_en(rd_en), .rd_addr(rd_addr_bus),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .clr_req(clr_req), .clr_busy(busy_b)
    );

    int checks = 0;
    int errors = 0;
    bit mon_on = 0;

    // Scoreboard state: index k = dut*2 + port
    logic [BW-1:0] exp_q [4][$];
    logic          exp_valid [4];
    logic [BW-1:0] last_data [4];
    logic          exp_busy;

    // Reference model: plain arrays, one per instance
    logic [BW-1:0] m [2][DEPTH];
    int            clr_left;
    int            clr_pos;

    function automatic logic [BW-1:0] dout(input int d, input int i);
        logic [2*BW-1:0] t;
        t = (d == 0) ? rd_data_a : rd_data_b;
        return t[i*BW +: BW];
    endfunction

    function automatic logic vout(input int d, input int i);
        logic [1:0] t;
        t = (d == 0) ? rd_valid_a : rd_valid_b;
        return t[i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model over the coming edge, then let the edge happen.
    task automatic tick();
        logic [BW-1:0] nm [DEPTH];
        logic [AW-1:0] a;
        logic [BW-1:0] v;
        if (rst) begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < DEPTH; k++) m[d][k] = '0;
            for (int k = 0; k < 4; k++) begin
                exp_valid[k] = 1'b0;
                last_data[k] = '0;
            end
            clr_left = 0;
            clr_pos  = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < DEPTH; k++) nm[k] = m[d][k];
                if (clr_left > 0) begin
                    nm[clr_pos] = '0;
                end else if (chip_en) begin
                    if (wr_en[0] && !(d == 1 && wa0 == 0)) nm[wa0] = wd0;
                    if (wr_en[1] && !(d == 1 && wa1 == 0)) nm[wa1] = wd1;
                end
                for (int i = 0; i < 2; i++) begin
                    a = (i == 0) ? ra0 : ra1;
                    if (chip_en && rd_en[i]) begin
                        v = nm[a];
                        exp_q[d*2+i].push_back(v);
                        last_data[d*2+i] = v;
                        exp_valid[d*2+i] = 1'b1;
                    end else begin
                        exp_valid[d*2+i] = 1'b0;
                    end
                end
                for (int k = 0; k < DEPTH; k++) m[d][k] = nm[k];
            end
            if (clr_left > 0) begin
                clr_left--;
                clr_pos++;
            end else if (clr_req && chip_en) begin
                clr_left = DEPTH;
                clr_pos  = 0;
            end
        end
        exp_busy = (clr_left > 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; chip_en = 1'b1; clr_req = 1'b0; wr_en = 2'b00; rd_en = 2'b00;
    endtask

    task automatic fill(input logic [BW-1:0] base);
        for (int a = 0; a < DEPTH; a += 2) begin
            idle();
            wr_en = 2'b11;
            wa0 = AW'(a);     wd0 = base + BW'(a);
            wa1 = AW'(a + 1); wd1 = base + BW'(a + 1);
            tick();
        end
        idle();
    endtask

    // Monitor: pops an expectation whenever a DUT port presents read data.
    initial begin
        logic [BW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < 2; i++) begin
                        checks++;
                        if (vout(d, i) !== exp_valid[d*2+i]) begin
                            errors++;
                            $display("FAIL rd_valid d%0d p%0d: got %b expected %b at %0t",
                                     d, i, vout(d, i), exp_valid[d*2+i], $time);
                        end
                        checks++;
                        if (vout(d, i) === 1'b1) begin
                            if (exp_q[d*2+i].size() == 0) begin
                                errors++;
                                $display("FAIL rd_data d%0d p%0d: got %0h with nothing expected at %0t",
                                         d, i, dout(d, i), $time);
                            end else begin
                                e = exp_q[d*2+i].pop_front();
                                if (dout(d, i) !== e) begin
                                    errors++;
                                    $display("FAIL rd_data d%0d p%0d: got %0h expected %0h at %0t",
                                             d, i, dout(d, i), e, $time);
                                end
                            end
                        end else if (dout(d, i) !== last_data[d*2+i]) begin
                            errors++;
                            $display("FAIL rd_hold d%0d p%0d: got %0h expected %0h at %0t",
                                     d, i, dout(d, i), last_data[d*2+i], $time);
                        end
                    end
                end
                checks++;
                if (busy_a !== exp_busy || busy_b !== exp_busy) begin
                    errors++;
                    $display("FAIL clr_busy: got %b/%b expected %b at %0t",
                             busy_a, busy_b, exp_busy, $time);
                end
            end
        end
    end

    initial begin
        int cnt_a, cnt_b;
        wa0 = '0; wa1 = '0; ra0 = '0; ra1 = '0; wd0 = '0; wd1 = '0;
        idle();
        clr_left = 0; clr_pos = 0; exp_busy = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        mon_on = 1;
        tick();
        chk("reset_valid", {30'd0, rd_valid_a}, 32'd0);
        chk("reset_data", {16'd0, rd_data_a}, 32'd0);
        chk("reset_busy", {31'd0, busy_b}, 32'd0);

        // Read after reset
        idle(); rd_en = 2'b11; ra0 = 4'd3; ra1 = 4'd15;
        tick();
        chk("post_reset_valid", {30'd0, rd_valid_a}, 32'd3);
        chk("post_reset_data", {16'd0, rd_data_a}, 32'd0);

        // Same-address conflict with same-cycle read
        idle(); wr_en = 2'b11; wa0 = 4'd4; wd0 = 8'h5A; wa1 = 4'd4; wd1 = 8'hA5;
        rd_en = 2'b01; ra0 = 4'd4;
        tick();
        chk("conflict_bypass", {24'd0, dout(0, 0)}, 32'hA5);
        idle(); rd_en = 2'b01; ra0 = 4'd4;
        tick();
        chk("conflict_later", {24'd0, dout(0, 0)}, 32'hA5);

        // chip_en gating
        idle(); chip_en = 1'b0; wr_en = 2'b01; wa0 = 4'd2; wd0 = 8'h77; rd_en = 2'b01; ra0 = 4'd2;
        tick();
        chk("gated_valid", {30'd0, rd_valid_a}, 32'd0);
        idle(); rd_en = 2'b01; ra0 = 4'd2;
        tick();
        chk("gated_read", {24'd0, dout(0, 0)}, 32'h00);

        // Hard-wired zero entry
        idle(); wr_en = 2'b01; wa0 = 4'd0; wd0 = 8'hFF; rd_en = 2'b01; ra0 = 4'd0;
        tick();
        chk("zero_same", {24'd0, dout(1, 0)}, 32'h00);
        chk("plain_same", {24'd0, dout(0, 0)}, 32'hFF);
        idle(); rd_en = 2'b01; ra0 = 4'd0;
        tick();
        chk("zero_next", {24'd0, dout(1, 0)}, 32'h00);

        // Clear with concurrent traffic
        fill(8'h10);
        clr_req = 1'b1;
        tick();
        cnt_a = busy_a ? 1 : 0;
        cnt_b = busy_b ? 1 : 0;
        for (int c = 1; c <= 20; c++) begin
            idle();
            if (c == 3) begin wr_en = 2'b01; wa0 = 4'd9; wd0 = 8'h33; end
            if (c == 4) begin rd_en = 2'b01; ra0 = 4'd9; end
            if (c == 5) begin rd_en = 2'b11; ra0 = 4'd12; ra1 = 4'd2; end
            tick();
            if (c == 4) chk("clr_write_dropped", {24'd0, dout(0, 0)}, 32'h19);
            if (c == 5) begin
                chk("clr_uncleared", {24'd0, dout(0, 0)}, 32'h1C);
                chk("clr_cleared", {24'd0, dout(0, 1)}, 32'h00);
            end
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
        end
        chk("clr_busy_len_a", cnt_a, 32'd16);
        chk("clr_busy_len_b", cnt_b, 32'd16);
        for (int a = 0; a < DEPTH; a += 2) begin
            idle(); rd_en = 2'b11; ra0 = AW'(a); ra1 = AW'(a + 1);
            tick();
            chk("post_clear", {16'd0, rd_data_a}, 32'd0);
        end

        // Reset in the middle of a clear
        fill(8'h20);
        clr_req = 1'b1;
        tick();
        idle();
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b1;
        tick();
        chk("rst_abort_busy", {30'd0, busy_a, busy_b}, 32'd0);
        idle(); rd_en = 2'b11; ra0 = 4'd7; ra1 = 4'd13;
        tick();
        chk("rst_abort_zero", {16'd0, rd_data_a}, 32'd0);
        fill(8'h40);
        clr_req = 1'b1;
        tick();
        chk("restart_busy", {31'd0, busy_a}, 32'd1);
        idle(); rd_en = 2'b11; ra0 = 4'd0; ra1 = 4'd1;
        tick();
        chk("restart_addr0", {24'd0, dout(0, 0)}, 32'h00);
        chk("restart_addr1", {24'd0, dout(0, 1)}, 32'h41);
        idle();
        for (int c = 0; c < 20; c++) tick();

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            chip_en = ($urandom_range(0, 9) != 0);
            clr_req = ($urandom_range(0, 59) == 0);
            wr_en   = 2'($urandom);
            rd_en   = 2'($urandom);
            wa0 = AW'($urandom); wa1 = AW'($urandom);
            wd0 = BW'($urandom); wd1 = BW'($urandom);
            ra0 = AW'($urandom); ra1 = AW'($urandom);
            if ($urandom_range(0, 3) == 0) wa1 = wa0;
            if ($urandom_range(0, 3) == 0) ra0 = wa1;
            if ($urandom_range(0, 7) == 0) ra1 = 4'd0;
            tick();
        end

        idle();
        tick();
        tick();
        for (int k = 0; k < 4; k++) chk("queue_drained", exp_q[k].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
